// File: rtl/ascii_char_fifo.sv
// rtl/ascii_char_fifo.sv - first-word fall-through buffer for converted characters with saturating cap counter
//
// Stores {cap, char} entries between the case converter and a slower sink.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_char (bit 0 = MSB), in_cap
//   out_valid/out_ready  downstream handshake; out_char (bit 0 = MSB), out_cap
//   count                number of stored entries
//   cap_clr, cap_count   synchronous clear / saturating count of accepted cap=1 entries
module ascii_char_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:7]       in_char,
    input  logic             in_cap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:7]       out_char,
    output logic             out_cap,
    output logic [PTR_W:0]   count,
    input  logic             cap_clr,
    output logic [CNT_W-1:0] cap_count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CAP_MAX  = {CNT_W{1'b1}};

    // Entry layout: bit 8 = cap, bits 7:0 = character (bit 7 carries in_char[0]).
    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] cap_count_q, cap_count_d;

    logic push;
    logic pop;
    logic [8:0] head;

    // Handshake outputs depend only on registered occupancy.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem_q[rd_ptr_q];
    // Storage is never reset, so the head is masked while empty.
    assign out_char  = out_valid ? head[7:0] : 8'h00;
    assign out_cap   = out_valid ? head[8]   : 1'b0;
    assign count     = count_q;
    assign cap_count = cap_count_q;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cap_count_d = cap_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_cap, in_char};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Clear takes priority over a simultaneous counted push.
        if (cap_clr) begin
            cap_count_d = '0;
        end else if (push && in_cap && (cap_count_q != CAP_MAX)) begin
            cap_count_d = cap_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cap_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cap_count_q <= cap_count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/ascii_char_fifo.md
# ascii_char_fifo

Elastic buffer directly downstream of the ASCII case converter. Stores each converted 8-bit character with its `cap` flag, and hands them in order to the next consumer over a valid/ready handshake. It decouples the combinational converter from a slower or stalling sink, such as a display or serial transmitter. It also keeps a saturating count of accepted characters whose `cap` flag was set.

## Interface
Parameters:
- `DEPTH`, 4 — number of entries; must be a power of two, ≥ 2.
- `CNT_W`, 16 — width of `cap_count`.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — a character is presented on `in_char`/`in_cap`.
- `in_ready`  out  1  — buffer can accept an entry this cycle.
- `in_char`  in  [0:7]  — converted character; bit 0 is MSB.
- `in_cap`  in  1  — `cap` flag accompanying `in_char`.
- `out_valid`  out  1  — head entry is available.
- `out_ready`  in  1  — consumer takes the head entry this cycle.
- `out_char`  out  [0:7]  — head character; bit 0 is MSB.
- `out_cap`  out  1  — head `cap` flag.
- `count`  out  log2(DEPTH)+1  — number of stored entries.
- `cap_clr`  in  1  — synchronous clear of `cap_count`.
- `cap_count`  out  CNT_W  — accepted entries with `in_cap`=1, saturating.

## Operation
- Storage holds `DEPTH` 9-bit entries {cap, char}, plus write pointer, read pointer and occupancy `count`.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Push happens when `in_valid` && `in_ready`. The entry is written at the write pointer, and the write pointer increments.
- Pop happens when `out_valid` && `out_ready`. The read pointer increments.
- `in_ready` = (`count` != DEPTH). It is derived only from registered state, never from `in_valid`.
- `out_valid` = (`count` != 0). It is derived only from registered state, never from `out_ready`.
- The buffer is first-word fall-through: `out_char`/`out_cap` show the head entry whenever `out_valid`=1. When `out_valid`=0 they are forced to 0.
- `count` update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Full case: `in_ready`=0, so no push can occur. A pop that cycle leaves `count`=DEPTH−1, and `in_ready` rises the next cycle.
- Empty case: `out_valid`=0, so no pop can occur. A push that cycle makes `count`=1, and `out_valid` rises the next cycle.
- Entries are never dropped or overwritten. An `in_valid` without `in_ready` has no effect; the upstream source must hold its data.
- `cap_count` update per cycle:
  - If `cap_clr`=1, it loads 0. Clear wins over a simultaneous increment.
  - Else, on a push with `in_cap`=1, it increments by 1, saturating at 2^CNT_W−1.
- Reset, asserted at any time including mid-transfer, takes effect immediately without a clock edge:
  - pointers = 0, `count` = 0, `cap_count` = 0
  - `out_valid` = 0, `out_char` = 0x00, `out_cap` = 0, `in_ready` = 1
  - All stored entries are discarded. Storage contents need no reset, because outputs are masked while empty.

## Timing
- Push-to-output latency: an entry pushed at edge N into an empty buffer appears on `out_*` with `out_valid`=1 after edge N.
- Throughput is one push and one pop per cycle, sustained, at any occupancy between 1 and DEPTH−1.
- `in_ready` and `out_valid` change only after a clock edge or on `rst` assertion.
- `count` and `cap_count` are registered and reflect transfers completed at the previous edge.
- After `rst` deasserts, the first push can be accepted at the first rising edge.

## Test plan
- **Reset:** assert `rst` mid-cycle with 2 entries stored → immediately `count`=0, `out_valid`=0, `out_char`=0x00, `in_ready`=1, `cap_count`=0.
- **Ordering:** push 0x41/cap1, 0x62/cap0, 0x7A/cap0, with `out_ready`=0.
  - Required: `count`=3, `cap_count`=1.
  - Then raise `out_ready`: `out_char` reads 0x41, 0x62, 0x7A on consecutive cycles, and `out_valid` drops after the third.
- **Full, DEPTH=4:** push 4 entries → `in_ready`=0 and `count`=4.
  - A 5th `in_valid` with 0x55 is ignored.
  - One pop → `in_ready`=1 next cycle, and 0x55 is then accepted as entry 4.
- **Simultaneous push and pop at `count`=2, held for 10 cycles:** `count` stays 2, output sequence matches input order, and pointers wrap without loss.
- **`cap_count` saturation, CNT_W=2:** push 5 entries with cap1 → `cap_count` sequence 1, 2, 3, 3.
  - `cap_clr` together with a cap1 push → `cap_count`=0.
- **Empty edge:** hold `out_ready`=1 on an empty buffer; push 0x30 → `out_valid`=1 for exactly one cycle with `out_char`=0x30, then `count`=0.
